// File: rtl/core_comm_endpoint.sv
// Core-side endpoint of the inter-core network: TX output register, fall-through RX FIFO,
// and the barrier participation FSM (state | meaning: IDLE idle, REQ arrive pending, WAIT awaiting release, DONE release seen).
module core_comm_endpoint #(
    parameter int CORE_ID        = 0,
    parameter int NUM_CORES      = 4,
    parameter int MSG_WIDTH      = 32,
    parameter int RX_DEPTH       = 4,
    parameter int NUM_BARRIERS   = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int ID_W  = $clog2(NUM_CORES),
    localparam int BID_W = $clog2(NUM_BARRIERS),
    localparam int CW    = $clog2(RX_DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    input  logic [ID_W-1:0]      tx_dest_i,
    input  logic [MSG_WIDTH-1:0] tx_data_i,
    output logic                 tx_err_o,
    output logic                 net_tx_valid_o,
    input  logic                 net_tx_ready_i,
    output logic [ID_W-1:0]      net_tx_src_o,
    output logic [ID_W-1:0]      net_tx_dest_o,
    output logic [MSG_WIDTH-1:0] net_tx_data_o,
    input  logic                 net_rx_valid_i,
    output logic                 net_rx_ready_o,
    input  logic [ID_W-1:0]      net_rx_src_i,
    input  logic [MSG_WIDTH-1:0] net_rx_data_i,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic [ID_W-1:0]      rx_src_o,
    output logic [MSG_WIDTH-1:0] rx_data_o,
    output logic [CW-1:0]        rx_count_o,
    input  logic                 bar_arrive_i,
    input  logic [BID_W-1:0]     bar_id_i,
    output logic                 bar_req_valid_o,
    input  logic                 bar_req_ready_i,
    output logic [BID_W-1:0]     bar_req_id_o,
    input  logic                 bar_release_i,
    input  logic [BID_W-1:0]     bar_release_id_i,
    output logic                 bar_wait_o,
    output logic                 bar_done_o,
    output logic                 bar_timeout_o,
    output logic                 bar_err_o
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BID_W:0]   NB         = (BID_W + 1)'(NUM_BARRIERS);
    localparam logic [CW-1:0]    FULL_CNT   = CW'(RX_DEPTH);

    // ---------------- TX output register ----------------
    logic                 net_tx_valid_q, tx_err_q;
    logic [ID_W-1:0]      net_tx_dest_q;
    logic [MSG_WIDTH-1:0] net_tx_data_q;
    logic                 tx_accept;

    assign tx_ready_o = !net_tx_valid_q || net_tx_ready_i;
    assign tx_accept  = tx_valid_i && tx_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            net_tx_valid_q <= 1'b0;
            net_tx_dest_q  <= '0;
            net_tx_data_q  <= '0;
            tx_err_q       <= 1'b0;
        end else begin
            tx_err_q <= 1'b0;
            if (tx_accept) begin
                // Self-addressed messages are swallowed; the slot is still freed.
                if (tx_dest_i == ID_W'(CORE_ID)) begin
                    tx_err_q       <= 1'b1;
                    net_tx_valid_q <= 1'b0;
                end else begin
                    net_tx_valid_q <= 1'b1;
                    net_tx_dest_q  <= tx_dest_i;
                    net_tx_data_q  <= tx_data_i;
                end
            end else if (net_tx_ready_i) begin
                net_tx_valid_q <= 1'b0;
            end
        end
    end

    assign net_tx_valid_o = net_tx_valid_q;
    assign net_tx_src_o   = ID_W'(CORE_ID);
    assign net_tx_dest_o  = net_tx_dest_q;
    assign net_tx_data_o  = net_tx_data_q;
    assign tx_err_o       = tx_err_q;

    // ---------------- RX FIFO ----------------
    logic [MSG_WIDTH-1:0] data_mem_q [RX_DEPTH];
    logic [ID_W-1:0]      src_mem_q  [RX_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 rx_push, rx_pop;

    assign net_rx_ready_o = (count_q != FULL_CNT);
    assign rx_valid_o     = (count_q != '0);
    assign rx_push        = net_rx_valid_i && net_rx_ready_o;
    assign rx_pop         = rx_valid_o && rx_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < RX_DEPTH; i++) begin
                data_mem_q[i] <= '0;
                src_mem_q[i]  <= '0;
            end
        end else begin
            if (rx_push) begin
                data_mem_q[wr_ptr_q] <= net_rx_data_i;
                src_mem_q[wr_ptr_q]  <= net_rx_src_i;
                wr_ptr_q             <= wr_ptr_q + AW'(1);
            end
            if (rx_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (rx_push && !rx_pop)      count_q <= count_q + CW'(1);
            else if (rx_pop && !rx_push) count_q <= count_q - CW'(1);
        end
    end

    assign rx_src_o   = src_mem_q[rd_ptr_q];
    assign rx_data_o  = data_mem_q[rd_ptr_q];
    assign rx_count_o = count_q;

    // ---------------- Barrier FSM ----------------
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} bar_state_e;
    bar_state_e       state_q;
    logic [BID_W-1:0] bar_id_q;
    logic [TW-1:0]    timer_q;
    logic             req_valid_q, wait_q, done_q, timeout_q, err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            bar_id_q    <= '0;
            timer_q     <= '0;
            req_valid_q <= 1'b0;
            wait_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                IDLE: if (bar_arrive_i) begin
                    if ({1'b0, bar_id_i} < NB) begin
                        bar_id_q    <= bar_id_i;
                        req_valid_q <= 1'b1;
                        wait_q      <= 1'b1;
                        state_q     <= REQ;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                REQ: if (bar_req_ready_i) begin
                    req_valid_q <= 1'b0;
                    timer_q     <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    // A matching release beats a timeout landing in the same cycle.
                    if (bar_release_i && bar_release_id_i == bar_id_q) begin
                        wait_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (timer_q == TIMER_LAST) begin
                        wait_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bar_req_valid_o = req_valid_q;
    assign bar_req_id_o    = bar_id_q;
    assign bar_wait_o      = wait_q;
    assign bar_done_o      = done_q;
    assign bar_timeout_o   = timeout_q;
    assign bar_err_o       = err_q;
endmodule
